// File: rtl/imm_decode_stage.sv
// Immediate decode stage: forms the sign-extended immediate and branch/jump target,
// then buffers results in a two-entry elastic buffer (output register plus skid register).
module imm_decode_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [2:0]            ImmSrc,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ImmOp,
  output logic [DATA_WIDTH-1:0] Target,
  output logic                  illegal
);

  logic [31:0]           w_imm32;
  logic                  w_illegal;
  logic [DATA_WIDTH-1:0] w_imm;
  logic [DATA_WIDTH-1:0] w_target;
  logic                  w_accept;
  logic                  w_outFree;
  logic                  w_unused;

  logic                  r_outValid;
  logic [DATA_WIDTH-1:0] r_outImm;
  logic [DATA_WIDTH-1:0] r_outTarget;
  logic                  r_outIllegal;
  logic                  r_skidValid;
  logic [DATA_WIDTH-1:0] r_skidImm;
  logic [DATA_WIDTH-1:0] r_skidTarget;
  logic                  r_skidIllegal;

  // The opcode field does not contribute to any immediate format.
  assign w_unused = ^instr[6:0];

  always_comb begin
    w_imm32   = '0;
    w_illegal = 1'b0;
    case (ImmSrc)
      3'b000:  w_imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001:  w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010:  w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      3'b011:  w_imm32 = {instr[31:12], 12'b0};
      3'b100:  w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_imm    = DATA_WIDTH'($signed(w_imm32));
  assign w_target = pc + w_imm;

  // in_ready depends only on skid occupancy (and reset), never on out_ready.
  assign in_ready  = rst_n & ~r_skidValid;
  assign w_accept  = in_valid & in_ready;
  assign w_outFree = ~r_outValid | out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid    <= 1'b0;
      r_outImm      <= '0;
      r_outTarget   <= '0;
      r_outIllegal  <= 1'b0;
      r_skidValid   <= 1'b0;
      r_skidImm     <= '0;
      r_skidTarget  <= '0;
      r_skidIllegal <= 1'b0;
    end else if (flush) begin
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
    end else if (w_outFree) begin
      // A full skid implies in_ready was low, so no accept can collide here.
      if (r_skidValid) begin
        r_outValid   <= 1'b1;
        r_outImm     <= r_skidImm;
        r_outTarget  <= r_skidTarget;
        r_outIllegal <= r_skidIllegal;
        r_skidValid  <= 1'b0;
      end else if (w_accept) begin
        r_outValid   <= 1'b1;
        r_outImm     <= w_imm;
        r_outTarget  <= w_target;
        r_outIllegal <= w_illegal;
      end else begin
        r_outValid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skidValid   <= 1'b1;
      r_skidImm     <= w_imm;
      r_skidTarget  <= w_target;
      r_skidIllegal <= w_illegal;
    end
  end

  assign out_valid = r_outValid;
  assign ImmOp     = r_outImm;
  assign Target    = r_outTarget;
  assign illegal   = r_outIllegal;

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the immediate, PC and target width; legal values are ≥32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 SHALL have port flush, input, 1 bit: synchronous discard of all buffered entries.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream entry is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the stage can accept an entry.
REQ-007 SHALL have port instr, input, 32 bits: the instruction word.
REQ-008 SHALL have port ImmSrc, input, 3 bits: the format select (000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal).
REQ-009 SHALL have port pc, input, DATA_WIDTH bits: the instruction address.
REQ-010 SHALL have port out_valid, output, 1 bit: the output entry is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the output entry.
REQ-012 SHALL have port ImmOp, output, DATA_WIDTH bits: the sign-extended immediate.
REQ-013 SHALL have port Target, output, DATA_WIDTH bits: pc + ImmOp, modulo 2^DATA_WIDTH.
REQ-014 SHALL have port illegal, output, 1 bit: ImmSrc was an illegal code for the output entry.

Function
REQ-015 SHALL form the immediate as follows, each sign-extended from instr[31] to DATA_WIDTH:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-016 SHALL, for illegal ImmSrc, produce ImmOp=0, Target=pc and illegal=1; a legal ImmSrc yields illegal=0.
REQ-017 SHALL accept an entry when in_valid && in_ready, and SHALL release the output entry when out_valid && out_ready.
REQ-018 SHALL be a two-entry elastic buffer (output register plus skid register), preserving entry order.
REQ-019 SHALL present an accepted entry at the outputs exactly 1 cycle later when the output register is empty or is draining that cycle.
REQ-020 SHALL drive in_ready directly from a register as NOT skid-occupied, with no combinational path from out_ready.
REQ-021 SHALL, when the output register is stalled and an accept occurs, store the entry in the skid register; in_ready is then 0 the next cycle.
REQ-022 SHALL, when the output register drains and the skid register is occupied, move the skid entry to the output register the next cycle; an accept in the same cycle goes to the skid register.
REQ-023 SHALL, while out_valid=1 and out_ready=0, hold ImmOp, Target and illegal stable.
REQ-024 SHALL compute ImmOp and Target before registering, so the outputs are register outputs.
REQ-025 SHALL, on flush=1, empty both entries next cycle; flush overrides a same-cycle accept (the entry is dropped) and a drain.
REQ-026 SHALL, at the 2^DATA_WIDTH boundary, wrap Target with no overflow indication.

Reset
REQ-027 SHALL, on rst_n=0 at a clock edge, clear both entries and set out_valid=0, ImmOp=0, Target=0 and illegal=0; reset has priority over flush and over all handshakes.
REQ-028 SHALL drive in_ready=0 while rst_n=0, and in_ready=1 in the first cycle after rst_n returns to 1.
REQ-029 SHALL discard all in-flight entries when reset is asserted mid-operation; none reappear after reset.

Verification
REQ-030 SHALL be covered by a bench with these directed scenarios:
- I: instr=0xFFF00093, ImmSrc=000, pc=0x100, out_ready=1 -> next cycle ImmOp=0xFFFFFFFF, Target=0x000000FF, illegal=0.
- B: instr=0xFE000EE3, ImmSrc=010, pc=0x200 -> ImmOp=0xFFFFFFFC, Target=0x000001FC.
- J then U, back-to-back:
  - instr=0x0080006F, ImmSrc=100, pc=0x1000 -> ImmOp=0x8, Target=0x1008.
  - instr=0x123450B7, ImmSrc=011 -> ImmOp=0x12345000.
  - Both appear on consecutive cycles with no bubble.
- Backpressure:
  - out_ready=0, three entries A, B, C offered on consecutive cycles -> A and B accepted; in_ready=0 after B; C held upstream; outputs hold A.
  - Then out_ready=1 -> A, B, C are delivered in order.
- Flush/illegal:
  - ImmSrc=101 -> illegal=1, ImmOp=0.
  - flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered entry is never output.
- Reset mid-stream: rst_n=0 for 1 cycle with both entries full -> out_valid=0, ImmOp=0, Target=0 next cycle; in_ready=1 the cycle after release.
